alu_issue_ctrl: RTL and testbench

- Synthesizable initiator and result collector for the 8-bit, 3-bit-opcode, 16-bit-result pipelined ALU.
- Accepts operation commands over a valid/ready interface and drives the ALU operand and opcode ports.
- Tracks the fixed ALU pipeline latency and captures each result into a small FIFO, tagged for the consumer.
- Sits between the datapath sequencer and the ALU, and uses credit-based issue so no result is ever dropped.

---
 rtl/alu_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller and result collector for the pipelined 8-bit ALU, with credit-based admission.
// Optional reference self-check of ALU results is enabled by defining ALU_SELF_CHECK_EN.
module alu_issue_ctrl #(
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk_p_i,
  input  logic             reset_p_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_inst_i,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [2:0]       alu_inst_o,
  input  logic [15:0]      alu_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [15:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic [2:0]       res_inst_o,
  output logic             busy_o
`ifdef ALU_SELF_CHECK_EN
  ,
  output logic             chk_err_o,
  output logic [15:0]      chk_err_cnt_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ALU_LAT:0]   pv_q, pv_d;
  logic [TAG_W-1:0]   tagPipe_q [ALU_LAT+1];
  logic [2:0]         instPipe_q [ALU_LAT+1];
  logic [7:0]         aluA_q, aluB_q;
  logic [2:0]         aluInst_q;
  logic               readyEn_q;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   fifoCount_q, fifoCount_d;
  logic [15:0]        memData_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   memTag_q [FIFO_DEPTH];
  logic [2:0]         memInst_q [FIFO_DEPTH];
  logic               accept, pushEn, popEn;
  int                 creditUsed;

  // Every in-flight op already owns a FIFO slot, so a push can never find the FIFO full.
  assign creditUsed  = int'(fifoCount_q) + $countones(pv_q);
  assign cmd_ready_o = readyEn_q & (creditUsed < FIFO_DEPTH);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign pushEn      = pv_q[ALU_LAT];
  assign res_valid_o = (fifoCount_q != '0);
  assign popEn       = res_valid_o & res_ready_i;

  assign alu_a_o    = aluA_q;
  assign alu_b_o    = aluB_q;
  assign alu_inst_o = aluInst_q;
  assign res_data_o = res_valid_o ? memData_q[rdPtr_q] : '0;
  assign res_tag_o  = res_valid_o ? memTag_q[rdPtr_q]  : '0;
  assign res_inst_o = res_valid_o ? memInst_q[rdPtr_q] : '0;
  assign busy_o     = (|pv_q) | res_valid_o;

  always_comb begin
    pv_d        = {pv_q[ALU_LAT-1:0], accept};
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fifoCount_d = fifoCount_q;
    if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
    if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
    case ({pushEn, popEn})
      2'b10:   fifoCount_d = fifoCount_q + 1'b1;
      2'b01:   fifoCount_d = fifoCount_q - 1'b1;
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      readyEn_q   <= 1'b0;
      pv_q        <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluInst_q   <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
      for (int k = 0; k <= ALU_LAT; k++) begin
        tagPipe_q[k]  <= '0;
        instPipe_q[k] <= '0;
      end
    end else begin
      readyEn_q   <= 1'b1;
      pv_q        <= pv_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
      if (accept) begin
        aluA_q    <= cmd_a_i;
        aluB_q    <= cmd_b_i;
        aluInst_q <= cmd_inst_i;
      end
      tagPipe_q[0]  <= cmd_tag_i;
      instPipe_q[0] <= cmd_inst_i;
      for (int k = 1; k <= ALU_LAT; k++) begin
        tagPipe_q[k]  <= tagPipe_q[k-1];
        instPipe_q[k] <= instPipe_q[k-1];
      end
    end
  end

  // Storage needs no reset; validity comes from the count, and a reset edge never writes.
  always_ff @(posedge clk_p_i) begin
    if (pushEn && !reset_p_i) begin
      memData_q[wrPtr_q] <= alu_data_i;
      memTag_q[wrPtr_q]  <= tagPipe_q[ALU_LAT];
      memInst_q[wrPtr_q] <= instPipe_q[ALU_LAT];
    end
  end

`ifdef ALU_SELF_CHECK_EN
  logic [15:0]      refResult, aExt, bExt;
  logic [7:0]       absA;
  logic             refChk, chkMiss;
  logic [15:0]      refPipe_q [ALU_LAT+1];
  logic [ALU_LAT:0] chkPipe_q;
  logic             chkErr_q;
  logic [15:0]      chkErrCnt_q;

  always_comb begin
    aExt      = {8'h00, cmd_a_i};
    bExt      = {8'h00, cmd_b_i};
    absA      = cmd_a_i[7] ? (8'h00 - cmd_a_i) : cmd_a_i;
    refChk    = (cmd_inst_i != 3'b111);
    refResult = '0;
    case (cmd_inst_i)
      3'b000:  refResult = aExt + bExt;
      3'b001:  refResult = bExt - aExt;
      3'b010:  refResult = aExt * bExt;
      3'b011:  refResult = {8'h00, cmd_a_i & cmd_b_i};
      3'b100:  refResult = {8'h00, cmd_a_i ^ cmd_b_i};
      3'b101:  refResult = {8'h00, absA};
      3'b110:  refResult = (bExt - aExt) << 2;
      default: refResult = '0;
    endcase
  end

  assign chkMiss       = pushEn & chkPipe_q[ALU_LAT] & (alu_data_i != refPipe_q[ALU_LAT]);
  assign chk_err_o     = chkErr_q;
  assign chk_err_cnt_o = chkErrCnt_q;

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      chkPipe_q   <= '0;
      chkErr_q    <= 1'b0;
      chkErrCnt_q <= '0;
      for (int k = 0; k <= ALU_LAT; k++) refPipe_q[k] <= '0;
    end else begin
      chkPipe_q    <= {chkPipe_q[ALU_LAT-1:0], refChk};
      refPipe_q[0] <= refResult;
      for (int k = 1; k <= ALU_LAT; k++) refPipe_q[k] <= refPipe_q[k-1];
      chkErr_q <= chkMiss;
      if (chkMiss && (chkErrCnt_q != 16'hFFFF)) chkErrCnt_q <= chkErrCnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: pipelined ALU model plus an in-order result scoreboard.
// Self-check outputs are exercised when ALU_SELF_CHECK_EN is defined.
module tb_alu_issue_ctrl;

   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_p_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [2:0]  cmd_inst_i = '0;
   logic [7:0]  cmd_a_i = '0;
   logic [7:0]  cmd_b_i = '0;
   logic [3:0]  cmd_tag_i = '0;
   logic [7:0]  alu_a_o, alu_b_o;
   logic [2:0]  alu_inst_o;
   logic [15:0] alu_data_i;
   logic        res_valid_o;
   logic        res_ready_i = 1'b0;
   logic [15:0] res_data_o;
   logic [3:0]  res_tag_o;
   logic [2:0]  res_inst_o;
   logic        busy_o;
`ifdef ALU_SELF_CHECK_EN
   logic        chk_err_o;
   logic [15:0] chk_err_cnt_o;
`endif

   typedef struct {
      logic [15:0] data;
      logic [3:0]  tag;
      logic [2:0]  inst;
   } expEntry_t;

   expEntry_t   expQ[$];
   int          checkCount = 0;
   int          errorCount = 0;
   bit          corruptX4 = 1'b0;
   bit          streamDone = 1'b0;
   logic [15:0] aluS1 = '0, aluS2 = '0;

   alu_issue_ctrl dut (
      .clk_p_i(clk), .reset_p_i(reset_p_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_inst_i(cmd_inst_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_tag_i(cmd_tag_i),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_inst_o(alu_inst_o), .alu_data_i(alu_data_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .res_tag_o(res_tag_o), .res_inst_o(res_inst_o), .busy_o(busy_o)
`ifdef ALU_SELF_CHECK_EN
      , .chk_err_o(chk_err_o), .chk_err_cnt_o(chk_err_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Behaviour of the real ALU; opcode 111 returns an arbitrary but known pattern.
   function automatic logic [15:0] aluOut(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] ax, bx;
      ax = {8'h00, a};
      bx = {8'h00, b};
      if (corruptX4 && op == 3'b110 && a == 8'd1 && b == 8'd3) return 16'h0000;
      case (op)
         3'b000:  return ax + bx;
         3'b001:  return bx - ax;
         3'b010:  return ax * bx;
         3'b011:  return {8'h00, a & b};
         3'b100:  return {8'h00, a ^ b};
         3'b101:  return {8'h00, a[7] ? (8'h00 - a) : a};
         3'b110:  return (bx - ax) << 2;
         default: return {a, b} ^ 16'h5A5A;
      endcase
   endfunction

   // Two-stage ALU: samples the held operands every edge, result visible two edges later.
   always @(posedge clk) begin
      aluS1 <= aluOut(alu_inst_o, alu_a_o, alu_b_o);
      aluS2 <= aluS1;
   end
   assign alu_data_i = aluS2;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable across the negedge, so this sees exactly what the next edge samples.
   always @(negedge clk) begin
      if (!reset_p_i) begin
         if (res_valid_o && res_ready_i) begin
            if (expQ.size() == 0) checkOutput("unexpected_result", 32'(res_data_o), 32'hFFFFFFFF);
            else begin
               expEntry_t e;
               e = expQ.pop_front();
               checkOutput("sb_data", 32'(res_data_o), 32'(e.data));
               checkOutput("sb_tag", 32'(res_tag_o), 32'(e.tag));
               checkOutput("sb_inst", 32'(res_inst_o), 32'(e.inst));
            end
         end
         if (cmd_valid_i && cmd_ready_o) begin
            expQ.push_back('{aluOut(cmd_inst_i, cmd_a_i, cmd_b_i), cmd_tag_i, cmd_inst_i});
            checkOutput("credit_bound", 32'(expQ.size() <= FIFO_DEPTH), 32'd1);
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] tag);
      bit accepted = 1'b0;
      cmd_valid_i = 1'b1;
      cmd_inst_i  = op;
      cmd_a_i     = a;
      cmd_b_i     = b;
      cmd_tag_i   = tag;
      for (int n = 0; n < 50 && !accepted; n++) begin
         accepted = cmd_ready_o;
         tick();
      end
      cmd_valid_i = 1'b0;
      if (!accepted) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic popOne(input logic [15:0] expData, input string name);
      int n = 0;
      while (!res_valid_o && n < 10) begin
         tick();
         n++;
      end
      checkOutput({name, "_valid"}, 32'(res_valid_o), 32'd1);
      checkOutput(name, 32'(res_data_o), 32'(expData));
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cyc;
      // Reset: all outputs low while held, ready rises once reset is released.
      tick();
      tick();
      checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_alu_ops", {13'd0, alu_inst_o, alu_a_o, alu_b_o}, 32'd0);
      checkOutput("rst_res_fields", {9'd0, res_inst_o, res_tag_o, res_data_o}, 32'd0);
      reset_p_i = 1'b0;
      tick();
      checkOutput("ready_after_rst", 32'(cmd_ready_o), 32'd1);

      // Single ADD: result lands three cycles after accept.
      $display("[TB] single ADD");
      applyStimulus(3'b000, 8'h7F, 8'h01, 4'd3);
      checkOutput("add_alu_a", 32'(alu_a_o), 32'h7F);
      cyc = 1;
      tick();
      while (!res_valid_o && cyc < 10) begin
         tick();
         cyc++;
      end
      checkOutput("add_latency", 32'(cyc), 32'd3);
      checkOutput("add_tag", 32'(res_tag_o), 32'd3);
      popOne(16'h0080, "add_data");
      checkOutput("add_idle_busy", 32'(busy_o), 32'd0);

      // Back-to-back issue fills all credit; a fifth op waits for a pop.
      $display("[TB] back-to-back and credit");
      applyStimulus(3'b001, 8'h05, 8'h03, 4'd1);
      applyStimulus(3'b010, 8'hFF, 8'hFF, 4'd2);
      applyStimulus(3'b101, 8'h80, 8'h00, 4'd3);
      applyStimulus(3'b011, 8'hF0, 8'h3C, 4'd4);
      cmd_valid_i = 1'b1;
      cmd_inst_i  = 3'b100;
      cmd_a_i     = 8'h0F;
      cmd_b_i     = 8'hF0;
      cmd_tag_i   = 4'd5;
      for (int n = 0; n < 5; n++) begin
         checkOutput("fifth_refused", 32'(cmd_ready_o), 32'd0);
         tick();
      end
      popOne(16'hFFFE, "b2b_sub");
      checkOutput("refill_ready", 32'(cmd_ready_o), 32'd1);
      tick();
      cmd_valid_i = 1'b0;
      popOne(16'hFE01, "b2b_mul");
      popOne(16'h0080, "b2b_abs");
      popOne(16'h0030, "b2b_and");
      popOne(16'h00FF, "b2b_xor");

      // Push and pop on the same edge with two entries held.
      $display("[TB] simultaneous push/pop");
      applyStimulus(3'b011, 8'hAA, 8'h0F, 4'd7);
      applyStimulus(3'b000, 8'h10, 8'h20, 4'd8);
      for (int n = 0; n < 4; n++) tick();
      applyStimulus(3'b111, 8'h12, 8'h34, 4'd9);
      tick();
      tick();
      checkOutput("pp_head0", 32'(res_data_o), 32'h000A);
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      checkOutput("pp_head1", 32'(res_data_o), 32'h0030);
      popOne(16'h0030, "pp_second");
      popOne(16'h486E, "pp_op111");
      checkOutput("pp_empty", 32'(res_valid_o), 32'd0);
      checkOutput("pp_busy", 32'(busy_o), 32'd0);

      // Stream of 20 XORs against a consumer that toggles every cycle.
      $display("[TB] XOR stream");
      fork
         begin
            for (int i = 0; i < 20; i++)
               applyStimulus(3'b100, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i));
            streamDone = 1'b1;
         end
         begin
            for (int c = 0; c < 400; c++) begin
               res_ready_i = ~res_ready_i;
               tick();
               if (streamDone && expQ.size() == 0) break;
            end
         end
      join
      res_ready_i = 1'b0;
      checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
      tick();
      checkOutput("stream_busy", 32'(busy_o), 32'd0);

      // Reset with two ops in flight: their results must never appear.
      $display("[TB] reset mid-flight");
      applyStimulus(3'b000, 8'h01, 8'h02, 4'd1);
      applyStimulus(3'b000, 8'h03, 8'h04, 4'd2);
      reset_p_i = 1'b1;
      tick();
      expQ.delete();
      reset_p_i = 1'b0;
      tick();
      checkOutput("rst_flight_busy", 32'(busy_o), 32'd0);
      for (int n = 0; n < 4; n++) begin
         checkOutput("rst_flight_no_result", 32'(res_valid_o), 32'd0);
         tick();
      end
      checkOutput("rst_flight_ready", 32'(cmd_ready_o), 32'd1);

`ifdef ALU_SELF_CHECK_EN
      begin
         int pulses;
         $display("[TB] self-check");
         checkOutput("chk_cnt_reset", 32'(chk_err_cnt_o), 32'd0);
         res_ready_i = 1'b1;
         corruptX4   = 1'b1;
         pulses      = 0;
         applyStimulus(3'b110, 8'd1, 8'd3, 4'd6);
         for (int n = 0; n < 8; n++) begin
            if (chk_err_o) pulses++;
            tick();
         end
         checkOutput("chk_bad_pulses", 32'(pulses), 32'd1);
         checkOutput("chk_bad_cnt", 32'(chk_err_cnt_o), 32'd1);
         corruptX4 = 1'b0;
         pulses    = 0;
         applyStimulus(3'b110, 8'd1, 8'd3, 4'd7);
         for (int n = 0; n < 8; n++) begin
            if (chk_err_o) pulses++;
            tick();
         end
         checkOutput("chk_good_pulses", 32'(pulses), 32'd0);
         checkOutput("chk_good_cnt", 32'(chk_err_cnt_o), 32'd1);
         res_ready_i = 1'b0;
      end
`endif

      tick();
      checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
